// File: rtl/exe_ctrl_pkg.sv
// Shared encodings for the Execute-stage multi-cycle FPU controller:
// op codes, FSM state encoding and default latency constants.
package exe_ctrl_pkg;

  localparam int unsigned OP_W        = 3;
  localparam int unsigned DEF_MUL_LAT = 4;
  localparam int unsigned DEF_DIV_LAT = 16;
  localparam int unsigned DEF_CNT_W   = 5;

  // Values 6 and 7 are reserved and treated as single-cycle ops.
  typedef enum logic [OP_W-1:0] {
    FPU_ADD  = 3'd0,
    FPU_SUB  = 3'd1,
    FPU_MUL  = 3'd2,
    FPU_DIV  = 3'd3,
    FPU_ITOF = 3'd4,
    FPU_FTOI = 3'd5
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/exe_lat_lookup.sv
// Combinational op -> total EX-cycle latency table.
module exe_lat_lookup
  import exe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT = DEF_DIV_LAT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic [OP_W-1:0]  op,
  output logic [CNT_W-1:0] lat
);

  always_comb begin
    lat = CNT_W'(1);
    case (op)
      FPU_MUL:  lat = CNT_W'(MUL_LAT);
      FPU_DIV:  lat = CNT_W'(DIV_LAT);
      FPU_ITOF: lat = CNT_W'(2);
      FPU_FTOI: lat = CNT_W'(2);
      default:  lat = CNT_W'(1);
    endcase
  end

endmodule

// File: rtl/exe_multicycle_ctrl.sv
// Execute-stage sequencer for iterative FPU ops: freezes IF/ID/EX while an op
// runs and flags when FPUOut is final for the EX/MEM latch.
module exe_multicycle_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT = DEF_DIV_LAT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IssueValid,
  input  logic [OP_W-1:0] IssueOp,
  input  logic            Flush,
  input  logic            DownStall,
  output logic            Stall,
  output logic            StartFpu,
  output logic [OP_W-1:0] OpLatched,
  output logic            ResultValid,
  output logic            Busy
);

  ctrl_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] lat;
  logic             stall_c, start_c, rv_c;

  exe_lat_lookup #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_lat (
    .op  (IssueOp),
    .lat (lat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Next-state, counter and handshake decode; Flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    stall_c = 1'b0;
    start_c = 1'b0;
    rv_c    = 1'b0;
    if (Flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IssueValid) begin
            if (lat <= CNT_W'(1)) begin
              rv_c = 1'b1;
            end else begin
              start_c = 1'b1;
              stall_c = 1'b1;
              op_d    = IssueOp;
              cnt_d   = CNT_W'(lat - CNT_W'(2));
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            stall_c = 1'b1;
            cnt_d   = CNT_W'(cnt_q - CNT_W'(1));
          end else begin
            rv_c    = 1'b1;
            state_d = DownStall ? HOLD : IDLE;
          end
        end
        HOLD: begin
          rv_c = 1'b1;
          if (!DownStall) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Combinational handshakes are forced low while reset is asserted.
  assign Stall       = stall_c & ~reset;
  assign StartFpu    = start_c & ~reset;
  assign ResultValid = rv_c & ~reset;
  assign OpLatched   = op_q;
  assign Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_exe_multicycle_ctrl.sv
// Directed self-checking bench for exe_multicycle_ctrl (MUL_LAT=4, DIV_LAT=16).
module tb_exe_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic       IssueValid;
  logic [2:0] IssueOp;
  logic       Flush;
  logic       DownStall;
  logic       Stall;
  logic       StartFpu;
  logic [2:0] OpLatched;
  logic       ResultValid;
  logic       Busy;

  int compared   = 0;
  int mismatched = 0;

  exe_multicycle_ctrl #(
    .MUL_LAT (4),
    .DIV_LAT (16),
    .CNT_W   (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .IssueValid  (IssueValid),
    .IssueOp     (IssueOp),
    .Flush       (Flush),
    .DownStall   (DownStall),
    .Stall       (Stall),
    .StartFpu    (StartFpu),
    .OpLatched   (OpLatched),
    .ResultValid (ResultValid),
    .Busy        (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_stall, input logic e_start,
                         input logic e_rv, input logic e_busy);
    chk({tag, ".stall"}, 8'(Stall), 8'(e_stall));
    chk({tag, ".start"}, 8'(StartFpu), 8'(e_start));
    chk({tag, ".rv"}, 8'(ResultValid), 8'(e_rv));
    chk({tag, ".busy"}, 8'(Busy), 8'(e_busy));
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Settle inputs of the current cycle, then sample mid-cycle.
  task automatic settle();
    #4;
  endtask

  initial begin
    reset = 1'b1; IssueValid = 1'b0; IssueOp = 3'd0; Flush = 1'b0; DownStall = 1'b0;
    #12;
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.op", 8'(OpLatched), 8'd0);
    reset = 1'b0;
    next_cyc();

    // 1: add completes in the same cycle
    IssueValid = 1'b1; IssueOp = 3'd0; settle();
    chk_out("add", 1'b0, 1'b0, 1'b1, 1'b0);
    next_cyc();
    IssueValid = 1'b0; settle();
    chk_out("idle1", 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();

    // 2: mul, four EX cycles
    IssueValid = 1'b1; IssueOp = 3'd2; settle();
    chk_out("mul.c0", 1'b1, 1'b1, 1'b0, 1'b0);
    next_cyc(); settle();
    chk_out("mul.c1", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mul.op", 8'(OpLatched), 8'd2);
    next_cyc(); settle();
    chk_out("mul.c2", 1'b1, 1'b0, 1'b0, 1'b1);
    next_cyc(); settle();
    chk_out("mul.c3", 1'b0, 1'b0, 1'b1, 1'b1);
    next_cyc();
    IssueValid = 1'b0; settle();
    chk_out("mul.c4", 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();

    // 3: div flushed on cycle 5
    IssueValid = 1'b1; IssueOp = 3'd3; settle();
    chk_out("div.c0", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      next_cyc(); settle();
      chk_out($sformatf("div.c%0d", c), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    next_cyc();
    Flush = 1'b1; settle();
    chk_out("div.flush", 1'b0, 1'b0, 1'b0, 1'b1);
    next_cyc();
    Flush = 1'b0; IssueValid = 1'b0; settle();
    chk_out("div.c6", 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();

    // 4: mul with DownStall on cycles 3-4
    IssueValid = 1'b1; IssueOp = 3'd2; settle();
    chk_out("hold.c0", 1'b1, 1'b1, 1'b0, 1'b0);
    next_cyc(); next_cyc(); next_cyc();
    DownStall = 1'b1; settle();
    chk_out("hold.c3", 1'b0, 1'b0, 1'b1, 1'b1);
    next_cyc(); settle();
    chk_out("hold.c4", 1'b0, 1'b0, 1'b1, 1'b1);
    next_cyc();
    DownStall = 1'b0; settle();
    chk_out("hold.c5", 1'b0, 1'b0, 1'b1, 1'b1);
    next_cyc();
    IssueValid = 1'b0; settle();
    chk_out("hold.c6", 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();

    // 5: back-to-back muls with IssueValid held
    IssueValid = 1'b1; IssueOp = 3'd2; settle();
    chk_out("b2b.c0", 1'b1, 1'b1, 1'b0, 1'b0);
    next_cyc(); next_cyc(); next_cyc(); settle();
    chk_out("b2b.c3", 1'b0, 1'b0, 1'b1, 1'b1);
    next_cyc(); settle();
    chk_out("b2b.c4", 1'b1, 1'b1, 1'b0, 1'b0);
    next_cyc(); next_cyc(); settle();
    chk_out("b2b.c6", 1'b1, 1'b0, 1'b0, 1'b1);
    next_cyc(); settle();
    chk_out("b2b.c7", 1'b0, 1'b0, 1'b1, 1'b1);
    next_cyc();
    IssueValid = 1'b0; settle();
    chk_out("b2b.c8", 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();

    // 6: async reset pulse mid-div, then a normal mul
    IssueValid = 1'b1; IssueOp = 3'd3; settle();
    chk_out("rdiv.c0", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 7; c++) next_cyc();
    #2 reset = 1'b1;
    #1;
    chk_out("rdiv.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rdiv.op", 8'(OpLatched), 8'd0);
    IssueValid = 1'b0;
    #1 reset = 1'b0;
    next_cyc();
    IssueValid = 1'b1; IssueOp = 3'd2; settle();
    chk_out("rmul.c0", 1'b1, 1'b1, 1'b0, 1'b0);
    next_cyc(); next_cyc(); settle();
    chk_out("rmul.c2", 1'b1, 1'b0, 1'b0, 1'b1);
    next_cyc(); settle();
    chk_out("rmul.c3", 1'b0, 1'b0, 1'b1, 1'b1);
    next_cyc();
    IssueValid = 1'b0; settle();
    chk_out("rmul.c4", 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();

    // Boundaries: itof (LAT=2), reserved op, flush while idle
    IssueValid = 1'b1; IssueOp = 3'd4; settle();
    chk_out("itof.c0", 1'b1, 1'b1, 1'b0, 1'b0);
    next_cyc(); settle();
    chk_out("itof.c1", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("itof.op", 8'(OpLatched), 8'd4);
    next_cyc();
    IssueOp = 3'd7; settle();
    chk_out("rsvd", 1'b0, 1'b0, 1'b1, 1'b0);
    next_cyc();
    IssueOp = 3'd2; Flush = 1'b1; settle();
    chk_out("iflush", 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();
    IssueValid = 1'b0; Flush = 1'b0; settle();
    chk_out("iflush.nx", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
